// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// control states and small mode-classification helpers.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSVD = 3'b111
    } usr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

    // Modes that move bits one position per step
    function automatic logic is_step_mode(usr_mode_e m);
        logic r;
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Right-moving modes report the departing LSB on sout_r, the rest on sout_l
    function automatic logic is_right_mode(usr_mode_e m);
        logic r;
        case (m)
            MODE_SHR, MODE_ROR, MODE_ASR: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_step.sv
// One-bit combinational step of the shift register for the given mode.
// Non-moving modes pass the register through unchanged.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  usr_mode_e        mode,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q_next,
    output logic             out_r,
    output logic             out_l
);

    assign out_r = q[0];
    assign out_l = q[WIDTH-1];

    always_comb begin
        q_next = q;
        case (mode)
            MODE_SHR: q_next = {sin_r, q[WIDTH-1:1]};
            MODE_SHL: q_next = {q[WIDTH-2:0], sin_l};
            MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_multi.sv
// Multi-step universal shift register: accepts an operation when idle and
// runs shift/rotate modes for a (saturated) number of one-bit steps.
module usr_multi
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_reg, state_next;
    usr_mode_e        mode_reg, mode_next;
    logic [CW-1:0]    remain_reg, remain_next;
    logic [WIDTH-1:0] pout_reg, pout_next;
    logic             sout_r_reg, sout_r_next;
    logic             sout_l_reg, sout_l_next;
    logic             done_reg, done_next;

    usr_mode_e        mode_in, step_mode;
    logic [CW-1:0]    steps;
    logic [WIDTH-1:0] q_next;
    logic             out_r, out_l, do_step;

    assign mode_in = usr_mode_e'(mode);

    // The first step happens on the acceptance edge, so the live mode input
    // drives the datapath while idle and the latched mode thereafter.
    assign step_mode = (state_reg == ST_RUN) ? mode_reg : mode_in;
    assign steps     = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q      (pout_reg),
        .mode   (step_mode),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q_next (q_next),
        .out_r  (out_r),
        .out_l  (out_l)
    );

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        remain_next = remain_reg;
        pout_next   = pout_reg;
        sout_r_next = sout_r_reg;
        sout_l_next = sout_l_reg;
        done_next   = 1'b0;
        do_step     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mode_next = mode_in;
                    if (mode_in == MODE_LOAD) begin
                        pout_next = pin;
                        done_next = 1'b1;
                    end else if (!is_step_mode(mode_in) || steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        do_step = 1'b1;
                        if (steps == CW'(1)) begin
                            done_next = 1'b1;
                        end else begin
                            state_next  = ST_RUN;
                            remain_next = steps - CW'(1);
                        end
                    end
                end
            end
            ST_RUN: begin
                do_step     = 1'b1;
                remain_next = remain_reg - CW'(1);
                if (remain_reg == CW'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (do_step) begin
            pout_next = q_next;
            if (is_right_mode(step_mode)) sout_r_next = out_r;
            else                          sout_l_next = out_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_HOLD;
            remain_reg <= '0;
            pout_reg   <= '0;
            sout_r_reg <= 1'b0;
            sout_l_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            remain_reg <= remain_next;
            pout_reg   <= pout_next;
            sout_r_reg <= sout_r_next;
            sout_l_reg <= sout_l_next;
            done_reg   <= done_next;
        end
    end

    assign pout   = pout_reg;
    assign sout_r = sout_r_reg;
    assign sout_l = sout_l_reg;
    assign busy   = (state_reg == ST_RUN);
    assign done   = done_reg;

endmodule

// File: tb/tb_usr_multi.sv
// Bench for usr_multi (WIDTH=4): directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model.
module tb_usr_multi;

    localparam int W  = 4;
    localparam int CW = $clog2(W) + 1;

    logic          clk, rst, start, sin_r, sin_l;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic [W-1:0]  pin, pout;
    logic          sout_r, sout_l, busy, done;

    usr_multi #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
        .pin(pin), .sin_r(sin_r), .sin_l(sin_l), .pout(pout),
        .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation is "steps still owed"; each edge pays one.
    logic [W-1:0] m_pout;
    logic         m_sr, m_sl, m_done;
    int           m_left;
    logic [2:0]   m_mode;

    task automatic m_step(input logic [2:0] md);
        logic [W-1:0] p;
        p = m_pout;
        case (md)
            3'd1: begin m_pout = (p >> 1) | (W'(sin_r) << (W-1));        m_sr = p[0];   end
            3'd2: begin m_pout = (p << 1) | W'(sin_l);                   m_sl = p[W-1]; end
            3'd4: begin m_pout = (p >> 1) | (W'(p[0]) << (W-1));         m_sr = p[0];   end
            3'd5: begin m_pout = (p << 1) | W'(p[W-1]);                  m_sl = p[W-1]; end
            3'd6: begin m_pout = (p >> 1) | (p & (W'(1) << (W-1)));      m_sr = p[0];   end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        int n;
        if (rst) begin
            m_pout = '0; m_sr = 1'b0; m_sl = 1'b0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_step(m_mode);
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (start) begin
                n = (int'(count) > W) ? W : int'(count);
                if (mode == 3'd3) begin
                    m_pout = pin;
                    m_done = 1'b1;
                end else if (mode == 3'd0 || mode == 3'd7 || n == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_mode = mode;
                    m_step(mode);
                    m_left = n - 1;
                    if (m_left == 0) m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pout",   64'(pout),   64'(m_pout));
            chk("sout_r", 64'(sout_r), 64'(m_sr));
            chk("sout_l", 64'(sout_l), 64'(m_sl));
            chk("busy",   64'(busy),   64'(m_left > 0));
            chk("done",   64'(done),   64'(m_done));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op(input logic [2:0] md, input int cnt, input logic [W-1:0] d);
        mode = md; count = CW'(cnt); pin = d; start = 1'b1;
    endtask

    task automatic load(input logic [W-1:0] d);
        op(3'd3, 0, d);
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; count = '0; pin = '0; sin_r = 1'b0; sin_l = 1'b0;
        cyc(2);
        check_en = 1'b1;
        chk("rst_pout", 64'(pout), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_sout", 64'({sout_r, sout_l}), 64'h0);
        rst = 1'b0;

        // LOAD
        op(3'd3, 0, 4'b1010); cyc(1); start = 1'b0;
        chk("load_pout", 64'(pout), 64'b1010);
        chk("load_done", 64'(done), 64'h1);
        chk("load_busy", 64'(busy), 64'h0);
        cyc(1);
        chk("load_done_end", 64'(done), 64'h0);

        // SHR x3 with live serial input
        op(3'd1, 3, 4'b0); sin_r = 1'b1; cyc(1); start = 1'b0;
        chk("shr1_pout", 64'(pout), 64'b1101);
        chk("shr1_busy", 64'(busy), 64'h1);
        sin_r = 1'b1; cyc(1);
        chk("shr2_pout", 64'(pout), 64'b1110);
        chk("shr2_busy", 64'(busy), 64'h1);
        sin_r = 1'b0; cyc(1);
        chk("shr3_pout", 64'(pout), 64'b0111);
        chk("shr3_busy", 64'(busy), 64'h0);
        chk("shr3_done", 64'(done), 64'h1);
        chk("shr3_sout_r", 64'(sout_r), 64'h0);

        // ROL x4 with ignored start/mode changes while busy
        load(4'b1001);
        op(3'd5, 4, 4'b0); cyc(1);
        mode = 3'd1; count = CW'(1);
        cyc(3); start = 1'b0;
        chk("rol_pout", 64'(pout), 64'b1001);
        chk("rol_done", 64'(done), 64'h1);
        chk("rol_sout_l", 64'(sout_l), 64'h1);
        cyc(1);

        // ASR x2, then saturating ASR count=7
        load(4'b1000);
        op(3'd6, 2, 4'b0); cyc(1); start = 1'b0; cyc(1);
        chk("asr2_pout", 64'(pout), 64'b1110);
        chk("asr2_done", 64'(done), 64'h1);
        op(3'd6, 7, 4'b0); cyc(1); start = 1'b0; cyc(2);
        chk("asr_sat_busy3", 64'(busy), 64'h1);
        cyc(1);
        chk("asr_sat_pout", 64'(pout), 64'b1111);
        chk("asr_sat_done", 64'(done), 64'h1);
        chk("asr_sat_busy4", 64'(busy), 64'h0);
        cyc(1);

        // Reset aborts SHL in flight
        load(4'b0110);
        op(3'd2, 4, 4'b0); sin_l = 1'b1; cyc(1); start = 1'b0; cyc(1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("abort_pout", 64'(pout), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        cyc(2);
        chk("abort_no_done", 64'(done), 64'h0);

        // Reserved mode and zero count
        load(4'b0101);
        op(3'd7, 2, 4'b0); cyc(1); start = 1'b0;
        chk("rsvd_pout", 64'(pout), 64'b0101);
        chk("rsvd_done", 64'(done), 64'h1);
        op(3'd1, 0, 4'b0); cyc(1); start = 1'b0;
        chk("cnt0_pout", 64'(pout), 64'b0101);
        chk("cnt0_done", 64'(done), 64'h1);
        chk("cnt0_busy", 64'(busy), 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            mode  = 3'($urandom_range(0, 7));
            count = CW'($urandom_range(0, 7));
            pin   = W'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            cyc(1);
        end
        rst = 1'b0; start = 1'b0;
        cyc(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_multi.md
USR_MULTI -- requirements
Module: usr_multi

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits, legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH)+1, count field width; derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only when idle.
REQ-006 mode  input  3  operation code, encodings as in REQ-015.
REQ-007 count  input  CW  number of one-bit steps for shift/rotate modes; legal range 0..WIDTH.
REQ-008 pin  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input entering at the MSB on right shifts.
REQ-010 sin_l  input  1  serial input entering at the LSB on left shifts.
REQ-011 pout  output  WIDTH  register contents.
REQ-012 sout_r / sout_l  output  1 each  registered LSB / MSB shifted out on the most recent step.
REQ-013 busy  output  1  high while steps remain after the current edge.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 Mode encodings: 000 HOLD, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL, 110 ASR; 111 is reserved and shall act as HOLD.
REQ-016 Idle means busy=0; start=1 while idle shall latch mode and count at that edge.
REQ-017 start while busy=1 shall be ignored, with no effect on the operation in progress.
REQ-018 LOAD shall set pout<=pin at the acceptance edge, leave sout_r/sout_l unchanged, and ignore count.
REQ-019 HOLD, reserved mode, or count=0 shall leave pout unchanged.
REQ-020 Cases of REQ-018/REQ-019 shall pulse done in the next cycle, with busy never asserted.
REQ-021 Shift/rotate with count=N≥1 shall perform step 1 at the acceptance edge and one further step per edge, N steps total.
REQ-022 busy shall be 1 after each step edge except the N-th; done shall be 1 for exactly the cycle after the N-th step edge.
REQ-023 SHR: pout<={sin_r, pout[W-1:1]}, sout_r<=pout[0].
REQ-024 SHL: pout<={pout[W-2:0], sin_l}, sout_l<=pout[W-1].
REQ-025 ROR/ROL: rotate by one bit, with the bit leaving the register also driven to sout_r/sout_l respectively.
REQ-026 ASR: shift right replicating pout[W-1]; sout_r<=pout[0].
REQ-027 Serial inputs shall be sampled live at every step edge, not latched at start.
REQ-028 count>WIDTH shall saturate to WIDTH steps.
REQ-029 The latched mode shall not change during an operation; mode input changes while busy shall be ignored.
REQ-030 done and a new acceptance may coincide: start in the done cycle (busy=0) shall be accepted.

Reset
REQ-031 rst=1 at an edge shall force pout=0, sout_r=0, sout_l=0, busy=0, done=0, and clear the step counter.
REQ-032 rst shall take priority over start and over any in-flight operation; the aborted operation shall produce no done.

Structure
REQ-033 A shared package usr_pkg shall hold the usr_mode_e enum (3-bit) and the mode encodings.
REQ-034 The combinational one-step datapath shall be a sub-module usr_step (inputs q, mode, sin_r, sin_l; outputs q_next, out_r, out_l), instantiated once.
REQ-035 The control shall be a two-state FSM, IDLE/RUN, with a CW-bit remaining-steps counter.

Verification (WIDTH=4)
REQ-036 rst=1, then LOAD pin=1010 -> pout=1010 after one edge; done pulses in the next cycle; busy stays 0.
REQ-037 pout=1010, SHR count=3, sin_r=1,1,0 on successive edges -> pout=1101, then 1110, then 0111; busy=1,1,0; done in the next cycle; sout_r=0.
REQ-038 pout=1001, ROL count=4 -> pout returns to 1001 after 4 edges; start pulses during busy are ignored.
REQ-039 pout=1000, ASR count=2 -> pout=1110; ASR count=7 saturates to 4 steps, giving 1111.
REQ-040 SHL count=4 in progress, rst asserted after 2 steps -> pout=0000, busy=0, no done pulse.
REQ-041 mode=111 with start -> pout unchanged and done pulses; count=0 with SHR -> pout unchanged and done pulses.
